issue_scheduler: RTL and testbench

Front-end issue controller for the Tomasulo core. It takes one instruction per cycle from the fetch queue and allocates a reorder-buffer (RB) entry at the tail. It selects a free reservation station of the matching class and drives the shared instruction broadcast (fu, RB_index, inst) that all reservation stations sample. It tracks RB occupancy from commit pulses and sequences halt/drain.

---
 rtl/issue_scheduler_pkg.sv | 40 ++++
 rtl/issue_scheduler_prio_pick.sv | 26 ++
 rtl/issue_scheduler.sv | 167 ++++++++++++++++
 tb/tb_issue_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_scheduler_pkg.sv
// Shared definitions for the issue scheduler: opcode map, idle encodings,
// instruction class and the opcode decoder.
package issue_scheduler_pkg;

    localparam int OPCODE_WIDTH = 6;

    localparam logic [OPCODE_WIDTH-1:0] INST_ADD  = 6'h01;
    localparam logic [OPCODE_WIDTH-1:0] INST_SUB  = 6'h02;
    localparam logic [OPCODE_WIDTH-1:0] INST_MUL  = 6'h03;
    localparam logic [OPCODE_WIDTH-1:0] INST_ADDI = 6'h04;
    localparam logic [OPCODE_WIDTH-1:0] INST_SUBI = 6'h05;
    localparam logic [OPCODE_WIDTH-1:0] INST_MULI = 6'h06;
    localparam logic [OPCODE_WIDTH-1:0] INST_LW   = 6'h10;
    localparam logic [OPCODE_WIDTH-1:0] INST_SW   = 6'h11;
    localparam logic [OPCODE_WIDTH-1:0] INST_HALT = 6'h3E;

    // Idle encodings of the broadcast for the default FU_INDEX=3 / RB_INDEX=4.
    localparam logic [2:0] FU_NONE = 3'b111;
    localparam logic [3:0] RB_NULL = 4'b1111;

    typedef enum logic [1:0] {
        CLS_ALU,
        CLS_MEM,
        CLS_HALT,
        CLS_ILLEGAL
    } inst_class_t;

    function automatic inst_class_t decode_class(input logic [OPCODE_WIDTH-1:0] opcode);
        inst_class_t cls;
        case (opcode)
            INST_ADD, INST_SUB, INST_MUL,
            INST_ADDI, INST_SUBI, INST_MULI: cls = CLS_ALU;
            INST_LW, INST_SW:                cls = CLS_MEM;
            INST_HALT:                       cls = CLS_HALT;
            default:                         cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/issue_scheduler_prio_pick.sv
// Lowest-index selector: returns the index of the lowest set request bit and
// whether any bit was set at all.
module prio_pick #(
    parameter int N  = 4,
    parameter int IW = 3
) (
    input  logic [N-1:0]  i_req,
    output logic [IW-1:0] o_idx,
    output logic          o_found
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        // NOTE: every output gets a default before the loop; otherwise an
        // all-zero request would leave o_idx holding its old value (a latch).
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx   = IW'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_scheduler.sv
// Front-end issue controller: accepts one instruction per cycle, allocates a
// reorder-buffer entry at the tail, picks a free reservation station of the
// right class and drives the one-cycle broadcast. Also sequences HALT drain.
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int                WORD_SIZE = 32,
    parameter int                FU_NUM    = 4,
    parameter int                FU_INDEX  = 3,
    parameter int                RB_SIZE   = 8,
    parameter int                RB_INDEX  = 4,
    parameter logic [FU_NUM-1:0] ALU_MASK  = 4'b0011,
    parameter logic [FU_NUM-1:0] MEM_MASK  = 4'b1100
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] inst_in,
    input  logic                 inst_valid,
    output logic                 inst_ready,
    input  logic [FU_NUM-1:0]    busy_in,
    input  logic                 commit,
    input  logic                 flush,
    output logic [FU_INDEX-1:0]  fu,
    output logic [RB_INDEX-1:0]  RB_index,
    output logic [WORD_SIZE-1:0] inst,
    output logic                 illegal,
    output logic                 halted
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam logic [FU_INDEX-1:0] L_FU_NONE = {FU_INDEX{1'b1}};
    localparam logic [RB_INDEX-1:0] L_RB_NULL = {RB_INDEX{1'b1}};
    localparam logic [RB_INDEX-1:0] L_RB_LAST = RB_INDEX'(RB_SIZE - 1);
    localparam logic [RB_INDEX-1:0] L_RB_FULL = RB_INDEX'(RB_SIZE);

    logic [1:0]           r_state;
    logic [RB_INDEX-1:0]  r_tail;
    logic [RB_INDEX-1:0]  r_count;
    logic [FU_NUM-1:0]    r_pend;
    logic [FU_INDEX-1:0]  r_fu;
    logic [RB_INDEX-1:0]  r_rb_index;
    logic [WORD_SIZE-1:0] r_inst;
    logic                 r_illegal;
    logic                 r_halted;

    logic [OPCODE_WIDTH-1:0] w_opcode;
    inst_class_t             w_class;
    logic [FU_NUM-1:0]       w_class_mask;
    logic [FU_NUM-1:0]       w_req;
    logic [FU_INDEX-1:0]     w_pick_idx;
    logic                    w_pick_found;
    logic                    w_needs_station;
    logic                    w_free;
    logic                    w_fire;
    logic                    w_alloc;
    logic                    w_commit_eff;
    logic [RB_INDEX-1:0]     w_tail_next;

    assign w_opcode = inst_in[WORD_SIZE-1 -: OPCODE_WIDTH];
    assign w_class  = decode_class(w_opcode);

    // Stations able to execute the incoming instruction's class.
    always_comb begin
        w_class_mask = '0;
        case (w_class)
            CLS_ALU: w_class_mask = ALU_MASK;
            CLS_MEM: w_class_mask = MEM_MASK;
            default: w_class_mask = '0;
        endcase
    end

    // A station issued last edge has not raised busy yet, so pend masks it.
    assign w_req = w_class_mask & ~busy_in & ~r_pend;

    prio_pick #(
        .N  (FU_NUM),
        .IW (FU_INDEX)
    ) u_prio_pick (
        .i_req   (w_req),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    assign w_needs_station = (w_class == CLS_ALU) || (w_class == CLS_MEM);
    assign w_free          = (r_count < L_RB_FULL) && w_pick_found;
    assign inst_ready      = (r_state == ST_RUN) && !flush &&
                             (w_needs_station ? w_free : 1'b1);

    assign w_fire       = inst_valid && inst_ready;
    assign w_alloc      = w_fire && (w_class != CLS_ILLEGAL);
    assign w_commit_eff = commit && (r_count != '0);
    assign w_tail_next  = (r_tail == L_RB_LAST) ? '0 : r_tail + 1'b1;

    // Issue state, occupancy tracking and the registered broadcast.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: all state here is written with <= so every branch sees the
        // values from before the edge, regardless of statement order.
        if (reset) begin
            r_state    <= ST_RUN;
            r_tail     <= '0;
            r_count    <= '0;
            r_pend     <= '0;
            r_fu       <= L_FU_NONE;
            r_rb_index <= L_RB_NULL;
            r_inst     <= '0;
            r_illegal  <= 1'b0;
            r_halted   <= 1'b0;
        end else if (flush && (r_state != ST_HALTED)) begin
            r_state    <= ST_RUN;
            r_tail     <= '0;
            r_count    <= '0;
            r_pend     <= '0;
            r_fu       <= L_FU_NONE;
            r_rb_index <= L_RB_NULL;
            r_inst     <= '0;
            r_illegal  <= 1'b0;
        end else begin
            r_fu       <= L_FU_NONE;
            r_rb_index <= L_RB_NULL;
            r_inst     <= '0;
            r_illegal  <= 1'b0;
            r_pend     <= '0;

            if (w_fire) begin
                case (w_class)
                    CLS_ALU, CLS_MEM: begin
                        r_fu       <= w_pick_idx;
                        r_rb_index <= r_tail;
                        r_inst     <= inst_in;
                        r_pend     <= FU_NUM'(1) << w_pick_idx;
                    end
                    CLS_HALT: begin
                        r_rb_index <= r_tail;
                        r_inst     <= inst_in;
                        r_state    <= ST_DRAIN;
                    end
                    default: r_illegal <= 1'b1;
                endcase
            end

            if (w_alloc) begin
                r_tail <= w_tail_next;
            end

            if (w_alloc && !w_commit_eff) begin
                r_count <= r_count + 1'b1;
            end else if (!w_alloc && w_commit_eff) begin
                r_count <= r_count - 1'b1;
            end

            if ((r_state == ST_DRAIN) && (r_count == '0)) begin
                r_state  <= ST_HALTED;
                r_halted <= 1'b1;
            end
        end
    end

    assign fu       = r_fu;
    assign RB_index = r_rb_index;
    assign inst     = r_inst;
    assign illegal  = r_illegal;
    assign halted   = r_halted;

endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench for issue_scheduler: directed stimulus with literal
// expectations, plus a per-cycle comparison against a behavioural model.
module tb_issue_scheduler;
    import issue_scheduler_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] inst_in;
    logic        inst_valid;
    logic        inst_ready;
    logic [3:0]  busy_in;
    logic        commit;
    logic        flush;
    logic [2:0]  fu;
    logic [3:0]  RB_index;
    logic [31:0] inst;
    logic        illegal;
    logic        halted;

    int n_checks = 0;
    int n_pass   = 0;

    issue_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .inst_in    (inst_in),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .busy_in    (busy_in),
        .commit     (commit),
        .flush      (flush),
        .fu         (fu),
        .RB_index   (RB_index),
        .inst       (inst),
        .illegal    (illegal),
        .halted     (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Occupancy, tail, the station issued on the previous edge and the
    // run/drain/halted phase, all kept as plain integers.
    int m_count = 0;
    int m_tail  = 0;
    int m_prev  = -1;
    int m_mode  = 0;   // 0 run, 1 drain, 2 halted

    // 0 = ALU, 1 = MEM, 2 = HALT, 3 = unknown
    function automatic int classify(input logic [31:0] word);
        logic [5:0] op;
        op = word[31:26];
        if (op inside {INST_ADD, INST_SUB, INST_MUL, INST_ADDI, INST_SUBI, INST_MULI}) return 0;
        if (op inside {INST_LW, INST_SW}) return 1;
        if (op == INST_HALT) return 2;
        return 3;
    endfunction

    // ALU work goes to stations 0-1, memory work to stations 2-3.
    function automatic int pick_station(input int cls, input logic [3:0] busy, input int prev);
        int lo, hi;
        lo = (cls == 0) ? 0 : 2;
        hi = lo + 1;
        for (int s = lo; s <= hi; s++) begin
            if (!busy[s] && s != prev) return s;
        end
        return -1;
    endfunction

    initial begin : compare
        int          cls, st, e_fu, e_rb, e_ill, e_ready;
        logic [31:0] e_inst, c_inst;
        logic        c_valid, c_commit, c_flush, c_reset, xfer;
        forever begin
            @(negedge clk);
            #4;
            c_reset  = reset;
            c_inst   = inst_in;
            c_valid  = inst_valid;
            c_commit = commit;
            c_flush  = flush;
            cls      = classify(c_inst);
            st       = pick_station(cls, busy_in, m_prev);
            if (m_mode != 0 || c_flush) e_ready = 0;
            else if (cls >= 2)          e_ready = 1;
            else                        e_ready = (st >= 0 && m_count < 8) ? 1 : 0;
            if (!c_reset) check("model_ready", {31'b0, inst_ready}, e_ready);
            xfer = c_valid && (e_ready == 1);

            @(posedge clk);
            #1;
            e_fu = int'(FU_NONE); e_rb = int'(RB_NULL); e_inst = '0; e_ill = 0;
            if (reset || c_reset) begin
                m_count = 0; m_tail = 0; m_prev = -1; m_mode = 0;
            end else if (c_flush && m_mode != 2) begin
                m_count = 0; m_tail = 0; m_prev = -1; m_mode = 0;
            end else begin
                int alloc, retire, next_mode;
                alloc     = 0;
                next_mode = m_mode;
                m_prev    = -1;
                if (xfer) begin
                    if (cls <= 1) begin
                        e_fu = st; e_rb = m_tail; e_inst = c_inst; m_prev = st; alloc = 1;
                    end else if (cls == 2) begin
                        e_rb = m_tail; e_inst = c_inst; alloc = 1; next_mode = 1;
                    end else begin
                        e_ill = 1;
                    end
                end
                if (m_mode == 1 && m_count == 0) next_mode = 2;
                retire  = (c_commit && m_count > 0) ? 1 : 0;
                m_count = m_count + alloc - retire;
                m_tail  = (m_tail + alloc) % 8;
                m_mode  = next_mode;
            end
            check("model_fu",      {29'b0, fu},       e_fu);
            check("model_rb",      {28'b0, RB_index}, e_rb);
            check("model_inst",    inst,              e_inst);
            check("model_illegal", {31'b0, illegal},  e_ill);
            check("model_halted",  {31'b0, halted},   (m_mode == 2) ? 1 : 0);
        end
    end

    // ---------------- directed stimulus ----------------
    localparam logic [31:0] ADD_W  = {INST_ADD,  5'd1, 5'd2, 5'd3, 11'd0};
    localparam logic [31:0] SUB_W  = {INST_SUB,  5'd4, 5'd5, 5'd6, 11'd0};
    localparam logic [31:0] LW_W   = {INST_LW,   5'd7, 5'd8, 16'h0010};
    localparam logic [31:0] HALT_W = {INST_HALT, 26'd0};
    localparam logic [31:0] BAD_W  = {6'h3F,     26'h155};

    task automatic drive(input logic v, input logic [31:0] w, input logic [3:0] b,
                         input logic c, input logic f);
        @(negedge clk);
        inst_valid = v; inst_in = w; busy_in = b; commit = c; flush = f;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic cycle(input logic v, input logic [31:0] w, input logic [3:0] b,
                         input logic c, input logic f);
        drive(v, w, b, c, f);
        settle();
    endtask

    initial begin : stimulus
        reset = 1'b1; inst_valid = 1'b0; inst_in = '0; busy_in = '0; commit = 1'b0; flush = 1'b0;
        #1;
        check("reset_fu",      {29'b0, fu},       {29'b0, FU_NONE});
        check("reset_rb",      {28'b0, RB_index}, {28'b0, RB_NULL});
        check("reset_inst",    inst,              32'h0);
        check("reset_illegal", {31'b0, illegal},  32'h0);
        check("reset_halted",  {31'b0, halted},   32'h0);
        @(negedge clk);
        reset = 1'b0;
        settle();

        // First ADD with all stations idle.
        cycle(1, ADD_W, 4'b0000, 0, 0);
        check("add0_fu", {29'b0, fu}, 0);
        check("add0_rb", {28'b0, RB_index}, 0);
        check("add0_inst", inst, ADD_W);
        // Station 0 still pending, so the next ADD goes to station 1.
        cycle(1, ADD_W, 4'b0000, 0, 0);
        check("add1_fu", {29'b0, fu}, 1);
        check("add1_rb", {28'b0, RB_index}, 1);
        // Both ALU stations busy: stall.
        drive(1, ADD_W, 4'b0011, 0, 0);
        #3 check("add2_stall_ready", {31'b0, inst_ready}, 0);
        settle();
        check("add2_stall_fu", {29'b0, fu}, {29'b0, FU_NONE});
        cycle(1, ADD_W, 4'b0011, 0, 0);
        cycle(1, ADD_W, 4'b0010, 0, 0);
        check("add2_fu", {29'b0, fu}, 0);
        check("add2_rb", {28'b0, RB_index}, 2);
        repeat (3) cycle(0, '0, 4'b0000, 1, 0);

        // LW with memory stations busy, then station 3 released.
        drive(1, LW_W, 4'b1100, 0, 0);
        #3 check("lw_stall_ready", {31'b0, inst_ready}, 0);
        settle();
        cycle(1, LW_W, 4'b0100, 0, 0);
        check("lw_fu", {29'b0, fu}, 3);
        check("lw_rb", {28'b0, RB_index}, 3);

        // Flush with a valid ADD: nothing broadcast, tail and count cleared.
        cycle(1, ADD_W, 4'b0000, 0, 1);
        check("flush_fu", {29'b0, fu}, {29'b0, FU_NONE});

        // Fill the RB from tail 0.
        for (int k = 0; k < 8; k++) begin
            cycle(1, ADD_W, 4'b0000, 0, 0);
            check("fill_rb", {28'b0, RB_index}, k);
        end
        drive(1, ADD_W, 4'b0000, 1, 0);
        #3 check("full_ready", {31'b0, inst_ready}, 0);
        settle();
        check("full_commit_fu", {29'b0, fu}, {29'b0, FU_NONE});
        cycle(1, SUB_W, 4'b0000, 0, 0);
        check("wrap_rb", {28'b0, RB_index}, 0);

        // Unknown opcode with the RB full: pulse only.
        cycle(1, BAD_W, 4'b0000, 0, 0);
        check("illegal_pulse", {31'b0, illegal}, 1);
        check("illegal_fu", {29'b0, fu}, {29'b0, FU_NONE});
        drive(1, ADD_W, 4'b0000, 0, 0);
        #3 check("illegal_count_kept", {31'b0, inst_ready}, 0);
        settle();
        check("illegal_drop", {31'b0, illegal}, 0);

        // HALT with two entries outstanding, then drain.
        cycle(0, '0, 4'b0000, 0, 1);
        cycle(1, ADD_W, 4'b0000, 0, 0);
        cycle(1, ADD_W, 4'b0000, 0, 0);
        cycle(1, HALT_W, 4'b0011, 0, 0);
        check("halt_rb", {28'b0, RB_index}, 2);
        check("halt_fu", {29'b0, fu}, {29'b0, FU_NONE});
        drive(1, ADD_W, 4'b0000, 1, 0);
        #3 check("drain_ready", {31'b0, inst_ready}, 0);
        settle();
        cycle(1, ADD_W, 4'b0000, 1, 0);
        cycle(1, ADD_W, 4'b0000, 1, 0);
        check("drain_not_halted", {31'b0, halted}, 0);
        cycle(1, ADD_W, 4'b0000, 0, 0);
        check("halted_set", {31'b0, halted}, 1);
        drive(1, ADD_W, 4'b0000, 0, 1);
        #3 check("halted_ready", {31'b0, inst_ready}, 0);
        settle();
        check("halted_flush_ignored", {31'b0, halted}, 1);
        check("halted_no_issue", {29'b0, fu}, {29'b0, FU_NONE});

        // Reset mid-broadcast clears the outputs without waiting for an edge.
        @(negedge clk);
        reset = 1'b1; inst_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        settle();
        cycle(1, ADD_W, 4'b0000, 0, 0);
        check("post_reset_fu", {29'b0, fu}, 0);
        check("post_reset_halted", {31'b0, halted}, 0);
        #1 reset = 1'b1;
        #1;
        check("async_reset_fu", {29'b0, fu}, {29'b0, FU_NONE});
        check("async_reset_rb", {28'b0, RB_index}, {28'b0, RB_NULL});
        check("async_reset_inst", inst, 32'h0);
        @(negedge clk);
        inst_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        settle();
        cycle(0, '0, 4'b0000, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
